// File: rtl/competition_ctrl.sv
// competition_ctrl: input-side controller for the competition display path.
// Synchronizes and debounces the start/play/clear buttons, turns each accepted
// press into a one-cycle event and runs the IDLE/PLAY/LOCK competition FSM that
// drives the view code and the play counter consumed by the display view.
//
// Event strobes: start_evt/play_evt/clear_evt are single-cycle, valid-only
// strobes (no ready); the FSM consumes them in the cycle they are high and any
// event it does not act on is dropped, never held over to a later cycle.
module competition_ctrl #(
  parameter int DEBOUNCE = 1000000,
  parameter int CNT_W    = 20,
  parameter int MAX_PLAY = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_play,
  input  logic       btn_clear,
  output logic [2:0] view,
  output logic [3:0] play_count,
  output logic       play_pulse
);

  // Button index map used by the conditioning array.
  localparam int BTN_START = 0;
  localparam int BTN_PLAY  = 1;
  localparam int BTN_CLEAR = 2;
  localparam int NUM_BTN   = 3;

  // Counter value at which a still-differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  // Count at which the competition locks.
  localparam logic [3:0] MAX_CNT = 4'(MAX_PLAY);

  // FSM state codes double as the view code (upper view bit is always 0).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_evt;

  logic start_evt;
  logic play_evt;
  logic clear_evt;

  assign btn_raw[BTN_START] = btn_start;
  assign btn_raw[BTN_PLAY]  = btn_play;
  assign btn_raw[BTN_CLEAR] = btn_clear;

  // ---------------------------------------------------------------------------
  // Per-button conditioning: 2-flop synchronizer, debounce counter, debounced
  // level and its previous value for rising-edge detection.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lvl_q, lvl_d;
    logic             lvl_prev_q, lvl_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for synchronizer, debounce counter and debounced level.
    always_comb begin
      sync1_d    = btn_raw[i];
      sync2_d    = sync1_q;
      lvl_d      = lvl_q;
      lvl_prev_d = lvl_q;
      cnt_d      = cnt_q;
      if (sync2_q != lvl_q) begin
        // Input disagrees with the accepted level: keep counting until it has
        // disagreed for DEBOUNCE consecutive cycles, then accept it.
        if (cnt_q == CNT_LAST) begin
          lvl_d = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Any agreement restarts the stability window, so glitches vanish.
        cnt_d = '0;
      end
    end

    // Conditioning registers; reset clears everything so no press survives it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        lvl_q      <= 1'b0;
        lvl_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= sync1_d;
        sync2_q    <= sync2_d;
        lvl_q      <= lvl_d;
        lvl_prev_q <= lvl_prev_d;
        cnt_q      <= cnt_d;
      end
    end

    // Press event: one cycle on the rising edge of the debounced level only.
    assign btn_evt[i] = lvl_q & ~lvl_prev_q;
  end

  assign start_evt = btn_evt[BTN_START];
  assign play_evt  = btn_evt[BTN_PLAY];
  assign clear_evt = btn_evt[BTN_CLEAR];

  // ---------------------------------------------------------------------------
  // Competition FSM. The state register is exported directly as the view code.
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       pulse_q, pulse_d;

  // Next-state and counter update; clear beats play beats start.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only start has meaning while idle; play and clear are ignored.
        if (start_evt) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (clear_evt) begin
          count_d = '0;
        end else if (play_evt) begin
          if (count_q < MAX_CNT) begin
            count_d = count_q + 4'd1;
            pulse_d = 1'b1;
            if (count_q + 4'd1 == MAX_CNT) begin
              state_d = ST_LOCK;
            end
          end
        end else if (start_evt) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        // Counter is frozen at MAX_PLAY; play presses are ignored here.
        if (clear_evt) begin
          count_d = '0;
          state_d = ST_PLAY;
        end else if (start_evt) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counter and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign view       = {1'b0, state_q};
  assign play_count = count_q;
  assign play_pulse = pulse_q;

endmodule

// File: tb/tb_competition_ctrl.sv
// Directed testbench for competition_ctrl with DEBOUNCE=4, MAX_PLAY=9.
module tb_competition_ctrl;

  localparam int DEB  = 4;
  localparam int MAXP = 9;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_play;
  logic       btn_clear;
  logic [2:0] view;
  logic [3:0] play_count;
  logic       play_pulse;

  int n_vec;
  int n_err;
  int pulse_cnt;

  competition_ctrl #(
    .DEBOUNCE(DEB),
    .CNT_W   (4),
    .MAX_PLAY(MAXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_play  (btn_play),
    .btn_clear (btn_clear),
    .view      (view),
    .play_count(play_count),
    .play_pulse(play_pulse)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count play_pulse cycles on the falling edge.
  always @(negedge clk) begin
    if (play_pulse === 1'b1) pulse_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_btn(input int idx, input logic val);
    case (idx)
      0: btn_start = val;
      1: btn_play  = val;
      default: btn_clear = val;
    endcase
  endtask

  // Clean press: held 10 cycles (event arrives at edge 7), then released.
  task automatic press(input int idx);
    @(posedge clk); #1;
    set_btn(idx, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    set_btn(idx, 1'b0);
    repeat (10) @(posedge clk);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    btn_start = 1'b1; btn_play = 1'b1; btn_clear = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL reset_view: got %0d expected 0", view); end
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", play_count); end
    n_vec++; if (play_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %0d expected 0", play_pulse); end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL start_edge6_view: got %0d expected 0", view); end
    settle();
    n_vec++; if (view !== 3'd1) begin n_err++; $display("FAIL start_edge7_view: got %0d expected 1", view); end
    #1;
    btn_start = 1'b0; btn_play = 1'b0; btn_clear = 1'b0;
    repeat (10) @(posedge clk);
    settle();
    n_vec++; if (view !== 3'd1) begin n_err++; $display("FAIL after_release_view: got %0d expected 1", view); end
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL after_release_count: got %0d expected 0", play_count); end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    btn_play = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_play = 1'b0;
    repeat (15) @(posedge clk);
    settle();
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL glitch_count: got %0d expected 0", play_count); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt - p0); end
  endtask

  task automatic test_hold();
    int p0;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    btn_play = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL hold_edge6_count: got %0d expected 0", play_count); end
    settle();
    n_vec++; if (play_count !== 4'd1) begin n_err++; $display("FAIL hold_edge7_count: got %0d expected 1", play_count); end
    n_vec++; if (play_pulse !== 1'b1) begin n_err++; $display("FAIL hold_edge7_pulse: got %0d expected 1", play_pulse); end
    settle();
    n_vec++; if (play_pulse !== 1'b0) begin n_err++; $display("FAIL hold_edge8_pulse: got %0d expected 0", play_pulse); end
    repeat (12) @(posedge clk);
    #2;
    n_vec++; if (play_count !== 4'd1) begin n_err++; $display("FAIL hold_count: got %0d expected 1", play_count); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL hold_pulses: got %0d expected 1", pulse_cnt - p0); end
    btn_play = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_lock();
    int p0;
    press(2);
    settle();
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL pre_lock_clear: got %0d expected 0", play_count); end
    p0 = pulse_cnt;
    for (int k = 0; k < MAXP; k++) press(1);
    settle();
    n_vec++; if (play_count !== 4'd9) begin n_err++; $display("FAIL lock_count: got %0d expected 9", play_count); end
    n_vec++; if (view !== 3'd2) begin n_err++; $display("FAIL lock_view: got %0d expected 2", view); end
    n_vec++; if (pulse_cnt - p0 !== 9) begin n_err++; $display("FAIL lock_pulses: got %0d expected 9", pulse_cnt - p0); end
    p0 = pulse_cnt;
    press(1);
    settle();
    n_vec++; if (play_count !== 4'd9) begin n_err++; $display("FAIL tenth_count: got %0d expected 9", play_count); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL tenth_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (view !== 3'd2) begin n_err++; $display("FAIL tenth_view: got %0d expected 2", view); end
  endtask

  task automatic test_lock_clear();
    press(2);
    settle();
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL lock_clear_count: got %0d expected 0", play_count); end
    n_vec++; if (view !== 3'd1) begin n_err++; $display("FAIL lock_clear_view: got %0d expected 1", view); end
    press(0);
    settle();
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL stop_view: got %0d expected 0", view); end
    press(1);
    settle();
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL idle_play_count: got %0d expected 0", play_count); end
  endtask

  task automatic test_start_retain();
    press(0);
    for (int k = 0; k < 4; k++) press(1);
    settle();
    n_vec++; if (play_count !== 4'd4) begin n_err++; $display("FAIL four_count: got %0d expected 4", play_count); end
    press(0);
    settle();
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL retain_view: got %0d expected 0", view); end
    n_vec++; if (play_count !== 4'd4) begin n_err++; $display("FAIL retain_count: got %0d expected 4", play_count); end
    press(0);
    settle();
    n_vec++; if (view !== 3'd1) begin n_err++; $display("FAIL restart_view: got %0d expected 1", view); end
  endtask

  task automatic test_simultaneous();
    int p0;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    btn_play = 1'b1; btn_clear = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn_play = 1'b0; btn_clear = 1'b0;
    repeat (10) @(posedge clk);
    settle();
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL simul_count: got %0d expected 0", play_count); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL simul_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (view !== 3'd1) begin n_err++; $display("FAIL simul_view: got %0d expected 1", view); end
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int k = 0; k < 5; k++) press(1);
    settle();
    n_vec++; if (play_count !== 4'd5) begin n_err++; $display("FAIL mid_pre_count: got %0d expected 5", play_count); end
    @(posedge clk); #1;
    btn_play = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL mid_rst_view: got %0d expected 0", view); end
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d expected 0", play_count); end
    n_vec++; if (play_pulse !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulse: got %0d expected 0", play_pulse); end
    btn_play = 1'b0;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL post_rst_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (play_count !== 4'd0) begin n_err++; $display("FAIL post_rst_count: got %0d expected 0", play_count); end
    n_vec++; if (view !== 3'd0) begin n_err++; $display("FAIL post_rst_view: got %0d expected 0", view); end
  endtask

  // Test sequence and final report.
  initial begin
    n_vec = 0;
    n_err = 0;
    pulse_cnt = 0;
    rst = 1'b0;
    btn_start = 1'b0; btn_play = 1'b0; btn_clear = 1'b0;
    test_reset();
    test_glitch();
    test_hold();
    test_lock();
    test_lock_clear();
    test_start_retain();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/competition_ctrl.md
Name: competition_ctrl

Overview:
- Input-side controller for the competition display path.
- Debounces the three player buttons and runs the competition state machine.
- Produces the `view` code and the 4-bit `play_count` that the display view consumes.
- Sits between the board push-buttons and the display view module; shares the same clock.

Parameters:
- DEBOUNCE, 1000000, consecutive stable cycles required before a button level is accepted (sim benches use 4).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE.
- MAX_PLAY, 9, play count at which the competition locks (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (rst=0 resets)
- btn_start  input  1  raw start/stop button, active-high, asynchronous to clk
- btn_play  input  1  raw play button, active-high, asynchronous
- btn_clear  input  1  raw clear button, active-high, asynchronous
- view  output  3  display view select: 0 = IDLE, 1 = PLAY, 2 = LOCK
- play_count  output  4  number of accepted plays, 0..MAX_PLAY
- play_pulse  output  1  one-cycle strobe, asserted in the cycle play_count increments

Behaviour:
- Reset (rst=0, asynchronous): view=0, play_count=0, play_pulse=0.
  - All synchronizer flops, debounced levels and debounce counters go to 0.
  - FSM goes to IDLE.
  - Release is synchronous to the next clk edge.
- Input conditioning, per button:
  - Two-flop synchronizer.
  - Debounce counter compares the synchronized value with the debounced level. If they differ, the counter increments; if they are equal, it clears to 0.
  - When the counter reaches DEBOUNCE-1 while they still differ, the debounced level takes the synchronized value and the counter clears.
  - Press event = one-cycle rising edge of the debounced level. Release produces no event.
  - A glitch shorter than DEBOUNCE cycles produces no event.
- Latency: FSM/output update is visible 2 + DEBOUNCE + 1 clk edges after a clean raw rising edge (7 edges with DEBOUNCE=4).
- FSM states: IDLE, PLAY, LOCK; view is 0, 1, 2 respectively (registered).
  - IDLE: start_evt -> PLAY, play_count unchanged. play_evt and clear_evt are ignored.
  - PLAY:
    - clear_evt -> play_count=0, stay in PLAY.
    - Else play_evt -> play_count+1 and play_pulse=1. If the new count equals MAX_PLAY -> LOCK.
    - Else start_evt -> IDLE, play_count retained.
  - LOCK:
    - clear_evt -> play_count=0, go to PLAY.
    - play_evt is ignored: no increment, no pulse.
    - start_evt -> IDLE, play_count retained.
- Simultaneous events in the same cycle: priority is clear > play > start. Exactly one action is taken per cycle; lower-priority events are dropped, not queued.
- play_count never exceeds MAX_PLAY and never wraps.
- play_pulse is high for exactly one cycle per accepted increment and is 0 otherwise.
- Holding a button produces one event only; the next event requires release, then a debounced re-press.
- Reset mid-debounce or mid-operation discards all pending events; no event is generated on reset release, even if a button is held. A held button is accepted only after DEBOUNCE stable cycles and then produces one event.

Test Plan (DEBOUNCE=4, MAX_PLAY=9):
- Reset with all buttons held high, then release rst -> view=0, play_count=0, play_pulse=0; one start event after 2+4+1 edges -> view=1.
- In PLAY, 3-cycle btn_play glitch -> no change. Clean press held 20 cycles -> play_count 0->1, play_pulse high exactly 1 cycle, no further increment while held.
- 9 clean play presses from PLAY -> play_count reaches 9, view=2. A 10th press -> play_count stays 9, play_pulse stays 0.
- In LOCK, press clear -> play_count=0, view=1. Press start -> view=0. Press play in IDLE -> play_count stays 0.
- btn_play and btn_clear raised in the same cycle with play_count=4 -> play_count=0, play_pulse=0, view=1.
- Assert rst mid-count (play_count=5, btn_play mid-debounce) -> all outputs 0 immediately (asynchronous). After release, no spurious play_pulse.
